rij_multicycle_ctrl: RTL and testbench

//  Multi-cycle main controller for the RIJ datapath (REGS, ALU, RAM_B, IF_M with IR/PC write enables).

---
 rtl/rij_multicycle_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_rij_multicycle_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rij_multicycle_ctrl.sv
// Multi-cycle main controller for the RIJ datapath: steps each instruction through
// IF/ID/EX/MEM/WB, drives datapath enables/selects/ALU op and counts retired instructions.
module rij_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       OP,
    input  logic [5:0]       func,
    input  logic             ZF,
    output logic             PC_Write,
    output logic [1:0]       PC_s,
    output logic             IR_Write,
    output logic             Write_Reg,
    output logic             Mem_Write,
    output logic [2:0]       ALU_OP,
    output logic             Set_ZF,
    output logic             Set_OF,
    output logic [1:0]       w_r_s,
    output logic [1:0]       wr_data_s,
    output logic             imm_s,
    output logic             rt_imm_s,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL,
        C_RTYPE,
        C_IARITH,
        C_LW,
        C_SW,
        C_BEQ,
        C_BNE,
        C_J,
        C_JAL,
        C_JR
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [1:0] PCS_INC4   = 2'b00;
    localparam logic [1:0] PCS_RS     = 2'b01;
    localparam logic [1:0] PCS_BRANCH = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    localparam logic [1:0] WRS_RD  = 2'b00;
    localparam logic [1:0] WRS_RT  = 2'b01;
    localparam logic [1:0] WRS_R31 = 2'b10;

    localparam logic [1:0] WDS_ALU = 2'b00;
    localparam logic [1:0] WDS_MEM = 2'b01;
    localparam logic [1:0] WDS_PC  = 2'b10;

    state_t     state_q;
    state_t     state_d;
    iclass_t    iclass;
    logic [2:0] dec_alu;
    logic       dec_sext;
    logic       dec_rt_imm;
    logic       dec_of;
    logic       retire;

    // IR is stable from the end of S_IF, so the decode can stay purely combinational.
    always_comb begin
        iclass     = C_ILLEGAL;
        dec_alu    = ALU_ADD;
        dec_sext   = 1'b0;
        dec_rt_imm = 1'b0;
        dec_of     = 1'b0;
        case (OP)
            OP_RTYPE: begin
                iclass = C_RTYPE;
                case (func)
                    FN_ADD:  begin dec_alu = ALU_ADD; dec_of = 1'b1; end
                    FN_SUB:  begin dec_alu = ALU_SUB; dec_of = 1'b1; end
                    FN_AND:  dec_alu = ALU_AND;
                    FN_OR:   dec_alu = ALU_OR;
                    FN_XOR:  dec_alu = ALU_XOR;
                    FN_NOR:  dec_alu = ALU_NOR;
                    FN_SLTU: dec_alu = ALU_SLTU;
                    FN_SLL:  dec_alu = ALU_SLL;
                    FN_JR:   iclass  = C_JR;
                    default: iclass  = C_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                iclass     = C_IARITH;
                dec_alu    = ALU_ADD;
                dec_sext   = 1'b1;
                dec_rt_imm = 1'b1;
                dec_of     = 1'b1;
            end
            OP_ANDI: begin
                iclass     = C_IARITH;
                dec_alu    = ALU_AND;
                dec_rt_imm = 1'b1;
            end
            OP_XORI: begin
                iclass     = C_IARITH;
                dec_alu    = ALU_XOR;
                dec_rt_imm = 1'b1;
            end
            OP_SLTIU: begin
                iclass     = C_IARITH;
                dec_alu    = ALU_SLTU;
                dec_rt_imm = 1'b1;
            end
            OP_LW: begin
                iclass     = C_LW;
                dec_sext   = 1'b1;
                dec_rt_imm = 1'b1;
            end
            OP_SW: begin
                iclass     = C_SW;
                dec_sext   = 1'b1;
                dec_rt_imm = 1'b1;
            end
            OP_BEQ: begin
                iclass   = C_BEQ;
                dec_alu  = ALU_SUB;
                dec_sext = 1'b1;
            end
            OP_BNE: begin
                iclass   = C_BNE;
                dec_alu  = ALU_SUB;
                dec_sext = 1'b1;
            end
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs; reset overrides everything to zero at the end.
    always_comb begin
        state_d   = S_IF;
        PC_Write  = 1'b0;
        PC_s      = PCS_INC4;
        IR_Write  = 1'b0;
        Write_Reg = 1'b0;
        Mem_Write = 1'b0;
        ALU_OP    = ALU_ADD;
        Set_ZF    = 1'b0;
        Set_OF    = 1'b0;
        w_r_s     = WRS_RD;
        wr_data_s = WDS_ALU;
        imm_s     = 1'b0;
        rt_imm_s  = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_IF: begin
                if (run) begin
                    IR_Write = 1'b1;
                    PC_Write = 1'b1;
                    state_d  = S_ID;
                end else begin
                    state_d  = S_IF;
                end
            end
            S_ID: begin
                case (iclass)
                    C_J: begin
                        PC_Write = 1'b1;
                        PC_s     = PCS_JUMP;
                    end
                    C_JR: begin
                        PC_Write = 1'b1;
                        PC_s     = PCS_RS;
                    end
                    C_JAL: begin
                        PC_Write  = 1'b1;
                        PC_s      = PCS_JUMP;
                        Write_Reg = 1'b1;
                        w_r_s     = WRS_R31;
                        wr_data_s = WDS_PC;
                    end
                    C_ILLEGAL: illegal = 1'b1;
                    default:   state_d = S_EX;
                endcase
            end
            S_EX: begin
                ALU_OP   = dec_alu;
                imm_s    = dec_sext;
                rt_imm_s = dec_rt_imm;
                case (iclass)
                    C_RTYPE, C_IARITH: begin
                        Set_ZF  = 1'b1;
                        Set_OF  = dec_of;
                        state_d = S_WB;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ, C_BNE: begin
                        Set_ZF = 1'b1;
                        if ((iclass == C_BEQ && ZF) || (iclass == C_BNE && !ZF)) begin
                            PC_Write = 1'b1;
                            PC_s     = PCS_BRANCH;
                        end
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                ALU_OP   = dec_alu;
                imm_s    = dec_sext;
                rt_imm_s = dec_rt_imm;
                if (iclass == C_SW) begin
                    Mem_Write = 1'b1;
                end else if (iclass == C_LW) begin
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                ALU_OP    = dec_alu;
                imm_s     = dec_sext;
                rt_imm_s  = dec_rt_imm;
                Write_Reg = 1'b1;
                w_r_s     = (iclass == C_RTYPE) ? WRS_RD : WRS_RT;
                wr_data_s = (iclass == C_LW) ? WDS_MEM : WDS_ALU;
            end
            default: begin
                ALU_OP  = 3'b000;
                state_d = S_IF;
            end
        endcase
        if (!rst) begin
            state_d   = S_IF;
            PC_Write  = 1'b0;
            PC_s      = 2'b00;
            IR_Write  = 1'b0;
            Write_Reg = 1'b0;
            Mem_Write = 1'b0;
            ALU_OP    = 3'b000;
            Set_ZF    = 1'b0;
            Set_OF    = 1'b0;
            w_r_s     = 2'b00;
            wr_data_s = 2'b00;
            imm_s     = 1'b0;
            rt_imm_s  = 1'b0;
            illegal   = 1'b0;
        end
    end

    // An instruction retires on the edge that returns the FSM from an active state to S_IF.
    assign retire = rst && (state_d == S_IF) &&
                    (state_q == S_ID || state_q == S_EX || state_q == S_MEM || state_q == S_WB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_cnt <= '0;
        end else if (retire) begin
            inst_cnt <= inst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_rij_multicycle_ctrl.sv
// Self-checking bench for rij_multicycle_ctrl: directed table, reset/run/wrap sequences
// and random instructions against a per-instruction cycle-sequence model.
module tb_rij_multicycle_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [5:0]       OP;
    logic [5:0]       func;
    logic             ZF;
    logic             PC_Write;
    logic [1:0]       PC_s;
    logic             IR_Write;
    logic             Write_Reg;
    logic             Mem_Write;
    logic [2:0]       ALU_OP;
    logic             Set_ZF;
    logic             Set_OF;
    logic [1:0]       w_r_s;
    logic [1:0]       wr_data_s;
    logic             imm_s;
    logic             rt_imm_s;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] inst_cnt;

    rij_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .OP(OP), .func(func), .ZF(ZF),
        .PC_Write(PC_Write), .PC_s(PC_s), .IR_Write(IR_Write), .Write_Reg(Write_Reg),
        .Mem_Write(Mem_Write), .ALU_OP(ALU_OP), .Set_ZF(Set_ZF), .Set_OF(Set_OF),
        .w_r_s(w_r_s), .wr_data_s(wr_data_s), .imm_s(imm_s), .rt_imm_s(rt_imm_s),
        .state(state), .illegal(illegal), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       wr;
        logic       mw;
        logic [2:0] alu;
        logic       szf;
        logic       sof;
        logic [1:0] wrs;
        logic [1:0] wds;
        logic       ims;
        logic       rti;
        logic       ill;
    } obs_t;

    typedef enum {K_ILL, K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR} kind_e;

    typedef struct {
        kind_e      kind;
        logic [2:0] alu;
        logic       sext;
        logic       rti;
        logic       of;
    } info_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zf;
        int         lat;
    } vec_t;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] exp_cnt;
    vec_t             tbl[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.st  = state;     o.pcw = PC_Write;  o.pcs = PC_s;      o.irw = IR_Write;
        o.wr  = Write_Reg; o.mw  = Mem_Write; o.alu = ALU_OP;    o.szf = Set_ZF;
        o.sof = Set_OF;    o.wrs = w_r_s;     o.wds = wr_data_s; o.ims = imm_s;
        o.rti = rt_imm_s;  o.ill = illegal;
        return o;
    endfunction

    // Mnemonic-level view of the instruction set: what each instruction means for the ALU.
    function automatic info_t classify(input logic [5:0] op, input logic [5:0] fn);
        info_t i;
        i = '{kind: K_ILL, alu: 3'b100, sext: 1'b0, rti: 1'b0, of: 1'b0};
        if (op == 6'd0) begin
            i.kind = K_R;
            case (fn)
                6'h20: begin i.alu = 3'b100; i.of = 1'b1; end
                6'h22: begin i.alu = 3'b101; i.of = 1'b1; end
                6'h24: i.alu = 3'b000;
                6'h25: i.alu = 3'b001;
                6'h26: i.alu = 3'b010;
                6'h27: i.alu = 3'b011;
                6'h2b: i.alu = 3'b110;
                6'h00: i.alu = 3'b111;
                6'h08: i.kind = K_JR;
                default: i.kind = K_ILL;
            endcase
        end else begin
            case (op)
                6'h08: i = '{kind: K_I,   alu: 3'b100, sext: 1'b1, rti: 1'b1, of: 1'b1};
                6'h0c: i = '{kind: K_I,   alu: 3'b000, sext: 1'b0, rti: 1'b1, of: 1'b0};
                6'h0e: i = '{kind: K_I,   alu: 3'b010, sext: 1'b0, rti: 1'b1, of: 1'b0};
                6'h0b: i = '{kind: K_I,   alu: 3'b110, sext: 1'b0, rti: 1'b1, of: 1'b0};
                6'h23: i = '{kind: K_LW,  alu: 3'b100, sext: 1'b1, rti: 1'b1, of: 1'b0};
                6'h2b: i = '{kind: K_SW,  alu: 3'b100, sext: 1'b1, rti: 1'b1, of: 1'b0};
                6'h04: i = '{kind: K_BEQ, alu: 3'b101, sext: 1'b1, rti: 1'b0, of: 1'b0};
                6'h05: i = '{kind: K_BNE, alu: 3'b101, sext: 1'b1, rti: 1'b0, of: 1'b0};
                6'h02: i.kind = K_J;
                6'h03: i.kind = K_JAL;
                default: i.kind = K_ILL;
            endcase
        end
        return i;
    endfunction

    function automatic int latency(input kind_e k);
        case (k)
            K_J, K_JR, K_JAL, K_ILL: return 2;
            K_BEQ, K_BNE:            return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected observation k cycles into an instruction started with run=1 then dropped.
    function automatic obs_t model_cycle(input info_t inf, input int k, input logic zf);
        obs_t e;
        int   n;
        e     = '0;
        e.alu = 3'b100;
        n     = latency(inf.kind);
        if (k == 0) begin
            e.pcw = 1'b1;
            e.irw = 1'b1;
            return e;
        end
        if (k >= n) return e;
        if (k == 1) begin
            e.st = 3'd1;
            case (inf.kind)
                K_J:   begin e.pcw = 1'b1; e.pcs = 2'b11; end
                K_JR:  begin e.pcw = 1'b1; e.pcs = 2'b01; end
                K_JAL: begin e.pcw = 1'b1; e.pcs = 2'b11; e.wr = 1'b1; e.wrs = 2'b10; e.wds = 2'b10; end
                K_ILL: e.ill = 1'b1;
                default: ;
            endcase
            return e;
        end
        e.alu = inf.alu;
        e.ims = inf.sext;
        e.rti = inf.rti;
        if (k == 2) begin
            e.st = 3'd2;
            if (inf.kind == K_R || inf.kind == K_I) begin
                e.szf = 1'b1;
                e.sof = inf.of;
            end else if (inf.kind == K_BEQ || inf.kind == K_BNE) begin
                e.szf = 1'b1;
                if ((inf.kind == K_BEQ && zf) || (inf.kind == K_BNE && !zf)) begin
                    e.pcw = 1'b1;
                    e.pcs = 2'b10;
                end
            end
        end else if (k == 3 && (inf.kind == K_LW || inf.kind == K_SW)) begin
            e.st = 3'd3;
            e.mw = (inf.kind == K_SW);
        end else begin
            e.st  = 3'd4;
            e.wr  = 1'b1;
            e.wrs = (inf.kind == K_R) ? 2'b00 : 2'b01;
            e.wds = (inf.kind == K_LW) ? 2'b01 : 2'b00;
        end
        return e;
    endfunction

    // Runs one instruction from S_IF (entered just after a falling edge) and returns its length.
    task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                                  input string tag, output int lat);
        info_t inf;
        obs_t  e;
        inf  = classify(op, fn);
        OP   = op;
        func = fn;
        ZF   = zf;
        run  = 1'b1;
        lat  = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            e = model_cycle(inf, k, zf);
            check_output($sformatf("%s cyc%0d", tag, k), 32'(observe()), 32'(e));
            @(negedge clk);
            run = 1'b0;
            lat++;
            if (state == 3'd0) break;
        end
        exp_cnt = exp_cnt + 1'b1;
        #1;
        check_output($sformatf("%s inst_cnt", tag), 32'(inst_cnt), 32'(exp_cnt));
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   lat;
        obs_t idle;
        tbl.push_back('{"add",   6'h00, 6'h20, 1'b0, 4});
        tbl.push_back('{"sub",   6'h00, 6'h22, 1'b1, 4});
        tbl.push_back('{"and",   6'h00, 6'h24, 1'b0, 4});
        tbl.push_back('{"or",    6'h00, 6'h25, 1'b0, 4});
        tbl.push_back('{"xor",   6'h00, 6'h26, 1'b0, 4});
        tbl.push_back('{"nor",   6'h00, 6'h27, 1'b0, 4});
        tbl.push_back('{"sltu",  6'h00, 6'h2b, 1'b0, 4});
        tbl.push_back('{"sll",   6'h00, 6'h00, 1'b0, 4});
        tbl.push_back('{"addi",  6'h08, 6'h11, 1'b0, 4});
        tbl.push_back('{"andi",  6'h0c, 6'h3f, 1'b0, 4});
        tbl.push_back('{"xori",  6'h0e, 6'h05, 1'b0, 4});
        tbl.push_back('{"sltiu", 6'h0b, 6'h20, 1'b0, 4});
        tbl.push_back('{"lw",    6'h23, 6'h08, 1'b0, 5});
        tbl.push_back('{"sw",    6'h2b, 6'h0c, 1'b0, 4});
        tbl.push_back('{"beq1",  6'h04, 6'h00, 1'b1, 3});
        tbl.push_back('{"beq0",  6'h04, 6'h00, 1'b0, 3});
        tbl.push_back('{"bne1",  6'h05, 6'h00, 1'b1, 3});
        tbl.push_back('{"bne0",  6'h05, 6'h00, 1'b0, 3});
        tbl.push_back('{"j",     6'h02, 6'h10, 1'b0, 2});
        tbl.push_back('{"jal",   6'h03, 6'h10, 1'b0, 2});
        tbl.push_back('{"jr",    6'h00, 6'h08, 1'b0, 2});
        tbl.push_back('{"ill_op",6'h3f, 6'h00, 1'b0, 2});
        tbl.push_back('{"ill_fn",6'h00, 6'h01, 1'b0, 2});

        idle     = '0;
        idle.alu = 3'b100;
        rst      = 1'b0;
        run      = 1'b1;
        OP       = 6'h00;
        func     = 6'h20;
        ZF       = 1'b0;
        exp_cnt  = '0;
        @(negedge clk);
        @(negedge clk);
        check_output("reset outputs", 32'(observe()), 32'h0);
        check_output("reset inst_cnt", 32'(inst_cnt), 32'h0);
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed table");
        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].op, tbl[i].fn, tbl[i].zf, tbl[i].name, lat);
            check_output($sformatf("%s latency", tbl[i].name), 32'(lat), 32'(tbl[i].lat));
        end

        $display("[TB] reset in the middle of add");
        OP   = 6'h00;
        func = 6'h20;
        run  = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        @(negedge clk);
        check_output("pre-reset state", 32'(state), 32'd2);
        #1 rst = 1'b0;
        #1;
        check_output("mid reset outputs", 32'(observe()), 32'h0);
        check_output("mid reset inst_cnt", 32'(inst_cnt), 32'h0);
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus(6'h00, 6'h20, 1'b0, "add after reset", lat);
        check_output("add after reset latency", 32'(lat), 32'd4);

        $display("[TB] run held low in S_IF");
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_output($sformatf("idle%0d outputs", i), 32'(observe()), 32'(idle));
            check_output($sformatf("idle%0d inst_cnt", i), 32'(inst_cnt), 32'(exp_cnt));
            @(negedge clk);
        end

        $display("[TB] counter wrap");
        while (exp_cnt != '1) apply_stimulus(6'h02, 6'h00, 1'b0, "j fill", lat);
        apply_stimulus(6'h02, 6'h00, 1'b0, "j wrap", lat);
        check_output("inst_cnt wraps to zero", 32'(inst_cnt), 32'h0);

        $display("[TB] random instructions");
        for (int n = 0; n < 150; n++) begin
            logic [5:0] rop;
            logic [5:0] rfn;
            logic       rzf;
            int         pick;
            rzf = 1'($urandom);
            if ($urandom_range(1, 0) == 0) begin
                pick = int'($urandom_range(tbl.size() - 1, 0));
                rop  = tbl[pick].op;
                rfn  = tbl[pick].fn;
            end else begin
                rop  = 6'($urandom);
                rfn  = 6'($urandom);
            end
            apply_stimulus(rop, rfn, rzf, $sformatf("rnd%0d op%h fn%h", n, rop, rfn), lat);
            check_output($sformatf("rnd%0d latency", n), 32'(lat),
                         32'(latency(classify(rop, rfn).kind)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
